// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline encodings: ALU opcodes, result-source selects and
// operand-forwarding selects used by the decode/execute boundary.
package rv_pipe_pkg;

   // ALU opcodes carried from decode into execute.
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;
   localparam logic [2:0] ALU_XOR = 3'b101;

   // Source of the value written back to the register file.
   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   // Where an execute-stage operand is taken from.
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   // True when the instruction's result comes from data memory (a load).
   function automatic logic is_load(input logic [1:0] result_src);
      return (result_src == RES_MEM);
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of decode-side inputs, MEM/WB forwarding buses and execute-side
// outputs around the ID/EX pipeline register.
interface id_ex_stage_if #(
   parameter int XLEN = 32,
   parameter int REGW = 5
);
   // pipeline control
   logic            stall;
   logic            flush;
   // decode stage
   logic            validD;
   logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
   logic [REGW-1:0] Rs1D, Rs2D, RdD;
   logic [2:0]      ALUControlD;
   logic            ALUSrcD, RegWriteD, MemWriteD, JumpD, BranchD;
   logic [1:0]      ResultSrcD;
   // forwarding buses
   logic [XLEN-1:0] ALUResultM, ResultW;
   logic [REGW-1:0] RdM, RdW;
   logic            RegWriteM, RegWriteW;
   // execute stage
   logic [XLEN-1:0] SrcAE, SrcBE, WriteDataE, ImmExtE, PCE, PCPlus4E;
   logic [2:0]      ALUControlE;
   logic [REGW-1:0] RdE;
   logic            RegWriteE, MemWriteE, JumpE, BranchE, validE;
   logic [1:0]      ResultSrcE;
   logic            LoadUse;

   modport master (
      output stall, flush, validD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
             Rs1D, Rs2D, RdD, ALUControlD, ALUSrcD, RegWriteD, MemWriteD,
             JumpD, BranchD, ResultSrcD, ALUResultM, ResultW, RdM, RdW,
             RegWriteM, RegWriteW,
      input  SrcAE, SrcBE, WriteDataE, ImmExtE, PCE, PCPlus4E, ALUControlE,
             RdE, RegWriteE, MemWriteE, JumpE, BranchE, validE, ResultSrcE,
             LoadUse
   );

   modport slave (
      input  stall, flush, validD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
             Rs1D, Rs2D, RdD, ALUControlD, ALUSrcD, RegWriteD, MemWriteD,
             JumpD, BranchD, ResultSrcD, ALUResultM, ResultW, RdM, RdW,
             RegWriteM, RegWriteW,
      output SrcAE, SrcBE, WriteDataE, ImmExtE, PCE, PCPlus4E, ALUControlE,
             RdE, RegWriteE, MemWriteE, JumpE, BranchE, validE, ResultSrcE,
             LoadUse
   );
endinterface

// File: rtl/id_ex_stage_forward_unit.sv
// Operand-forwarding select logic. Purely combinational so it can also
// serve the branch comparator. MEM beats WB; x0 is never forwarded.
module forward_unit
   import rv_pipe_pkg::*;
#(
   parameter int REGW = 5
) (
   input  logic [REGW-1:0] Rs1E,
   input  logic [REGW-1:0] Rs2E,
   input  logic [REGW-1:0] RdM,
   input  logic [REGW-1:0] RdW,
   input  logic            RegWriteM,
   input  logic            RegWriteW,
   output fwd_sel_t        ForwardAE,
   output fwd_sel_t        ForwardBE
);

   // Pick the youngest in-flight producer of register rs, if any.
   function automatic fwd_sel_t pick(input logic [REGW-1:0] rs,
                                     input logic [REGW-1:0] rd_m,
                                     input logic [REGW-1:0] rd_w,
                                     input logic            wr_m,
                                     input logic            wr_w);
      fwd_sel_t sel;
      if (wr_m && (rd_m != {REGW{1'b0}}) && (rd_m == rs)) begin
         sel = FWD_MEM;
      end else if (wr_w && (rd_w != {REGW{1'b0}}) && (rd_w == rs)) begin
         sel = FWD_WB;
      end else begin
         sel = FWD_RF;
      end
      return sel;
   endfunction

   // Independent select for each execute operand.
   always_comb begin
      ForwardAE = pick(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
      ForwardBE = pick(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding into the ALU and
// load-use hazard detection toward the hazard unit.
module id_ex_stage
   import rv_pipe_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int REGW = 5
) (
   input  logic          clk,
   input  logic          rst,
   id_ex_stage_if.slave  bus
);

   logic [XLEN-1:0] rd1_r, rd2_r, imm_r, pc_r, pc4_r;
   logic [REGW-1:0] rs1_r, rs2_r, rd_r;
   logic [2:0]      alu_ctrl_r;
   logic [1:0]      result_src_r;
   logic            alu_src_r, reg_write_r, mem_write_r, jump_r, branch_r;
   logic            valid_r;

   fwd_sel_t        fwd_a_sel_s, fwd_b_sel_s;
   logic [XLEN-1:0] fwd_a_s, fwd_b_s, src_b_s;
   logic            load_use_s;

   // Select one of register file / WB result / MEM result.
   function automatic logic [XLEN-1:0] fwd_mux(input fwd_sel_t        sel,
                                                input logic [XLEN-1:0] rf,
                                                input logic [XLEN-1:0] wb,
                                                input logic [XLEN-1:0] mem);
      logic [XLEN-1:0] v;
      case (sel)
         FWD_MEM: v = mem;
         FWD_WB:  v = wb;
         FWD_RF:  v = rf;
         default: v = rf;
      endcase
      return v;
   endfunction

   // E register update: reset/flush insert a bubble, stall freezes, else capture D.
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         rd1_r        <= {XLEN{1'b0}};
         rd2_r        <= {XLEN{1'b0}};
         imm_r        <= {XLEN{1'b0}};
         pc_r         <= {XLEN{1'b0}};
         pc4_r        <= {XLEN{1'b0}};
         rs1_r        <= {REGW{1'b0}};
         rs2_r        <= {REGW{1'b0}};
         rd_r         <= {REGW{1'b0}};
         alu_ctrl_r   <= ALU_ADD;
         result_src_r <= RES_ALU;
         alu_src_r    <= 1'b0;
         reg_write_r  <= 1'b0;
         mem_write_r  <= 1'b0;
         jump_r       <= 1'b0;
         branch_r     <= 1'b0;
         valid_r      <= 1'b0;
      end else if (bus.stall) begin
         rd1_r        <= rd1_r;
         rd2_r        <= rd2_r;
         imm_r        <= imm_r;
         pc_r         <= pc_r;
         pc4_r        <= pc4_r;
         rs1_r        <= rs1_r;
         rs2_r        <= rs2_r;
         rd_r         <= rd_r;
         alu_ctrl_r   <= alu_ctrl_r;
         result_src_r <= result_src_r;
         alu_src_r    <= alu_src_r;
         reg_write_r  <= reg_write_r;
         mem_write_r  <= mem_write_r;
         jump_r       <= jump_r;
         branch_r     <= branch_r;
         valid_r      <= valid_r;
      end else begin
         rd1_r        <= bus.RD1D;
         rd2_r        <= bus.RD2D;
         imm_r        <= bus.ImmExtD;
         pc_r         <= bus.PCD;
         pc4_r        <= bus.PCPlus4D;
         rs1_r        <= bus.Rs1D;
         rs2_r        <= bus.Rs2D;
         rd_r         <= bus.RdD;
         alu_ctrl_r   <= bus.ALUControlD;
         result_src_r <= bus.ResultSrcD;
         alu_src_r    <= bus.ALUSrcD;
         // an empty decode slot must not commit side effects
         reg_write_r  <= bus.RegWriteD & bus.validD;
         mem_write_r  <= bus.MemWriteD & bus.validD;
         jump_r       <= bus.JumpD & bus.validD;
         branch_r     <= bus.BranchD & bus.validD;
         valid_r      <= bus.validD;
      end
   end

   forward_unit #(.REGW(REGW)) u_fwd (
      .Rs1E      (rs1_r),
      .Rs2E      (rs2_r),
      .RdM       (bus.RdM),
      .RdW       (bus.RdW),
      .RegWriteM (bus.RegWriteM),
      .RegWriteW (bus.RegWriteW),
      .ForwardAE (fwd_a_sel_s),
      .ForwardBE (fwd_b_sel_s)
   );

   // Resolve operands in the same cycle from registered values and M/W buses.
   always_comb begin
      fwd_a_s = fwd_mux(fwd_a_sel_s, rd1_r, bus.ResultW, bus.ALUResultM);
      fwd_b_s = fwd_mux(fwd_b_sel_s, rd2_r, bus.ResultW, bus.ALUResultM);
      if (alu_src_r) begin
         src_b_s = imm_r;
      end else begin
         src_b_s = fwd_b_s;
      end
   end

   // A load in E whose destination is read by the instruction in D.
   always_comb begin
      load_use_s = 1'b0;
      if (valid_r && is_load(result_src_r) && (rd_r != {REGW{1'b0}}) &&
          ((rd_r == bus.Rs1D) || (rd_r == bus.Rs2D))) begin
         load_use_s = 1'b1;
      end else begin
         load_use_s = 1'b0;
      end
   end

   assign bus.SrcAE       = fwd_a_s;
   assign bus.SrcBE       = src_b_s;
   assign bus.WriteDataE  = fwd_b_s;
   assign bus.ImmExtE     = imm_r;
   assign bus.PCE         = pc_r;
   assign bus.PCPlus4E    = pc4_r;
   assign bus.ALUControlE = alu_ctrl_r;
   assign bus.RdE         = rd_r;
   assign bus.RegWriteE   = reg_write_r;
   assign bus.MemWriteE   = mem_write_r;
   assign bus.JumpE       = jump_r;
   assign bus.BranchE     = branch_r;
   assign bus.validE      = valid_r;
   assign bus.ResultSrcE  = result_src_r;
   assign bus.LoadUse     = load_use_s;

endmodule
